fetch_unit: RTL

Instruction-fetch stage of the 5-stage RV32I pipeline. Generates the fetch PC, issues requests to instruction memory over a request/response handshake, and buffers up to two in-flight fetches in a 2-entry in-order queue. Presents a registered {instruction, PC, valid} triple to the decode stage. Redirects from execute (branch/jump) and stalls from the hazard unit are applied here; wrong-path responses are dropped.

---
 rtl/fetch_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC generation, imem request/response with a 2-entry in-order queue, registered decode triple.
// Latency: response edge -> o_Valid (bypass); backpressure: i_Stall freezes the output, issue stops at entries+drops == 2.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_Stall,
   input  logic        i_Redirect,
   input  logic [31:0] i_RedirectPc,
   output logic        o_ImemReq,
   output logic [31:0] o_ImemAddr,
   input  logic        i_ImemReady,
   input  logic        i_ImemRvalid,
   input  logic [31:0] i_ImemRdata,
   output logic [31:0] o_Instr,
   output logic [31:0] o_Pc,
   output logic        o_Valid
);

   logic [31:0] fetch_pc;
   logic [31:0] ent_pc  [2];
   logic [31:0] ent_dat [2];
   logic [1:0]  ent_vld;
   logic [1:0]  ent_fill;
   logic        alloc_ptr;
   logic        fill_ptr;
   logic        pop_ptr;
   logic [1:0]  drop_cnt;

   logic [1:0]  ent_cnt;
   logic [1:0]  unfilled;
   logic [2:0]  occupancy;
   logic        accept;
   logic        resp_drop;
   logic        fill_hit;
   logic        head_rdy;
   logic        pop;
   logic [31:0] head_dat;
   logic [31:0] redirect_aligned;

   always_comb begin
      ent_cnt          = {1'b0, ent_vld[0]} + {1'b0, ent_vld[1]};
      unfilled         = {1'b0, ent_vld[0] & ~ent_fill[0]} + {1'b0, ent_vld[1] & ~ent_fill[1]};
      occupancy        = {1'b0, ent_cnt} + {1'b0, drop_cnt};
      o_ImemReq        = (occupancy < 3'd2) & ~i_Redirect;
      o_ImemAddr       = fetch_pc;
      accept           = o_ImemReq & i_ImemReady;
      // Stale responses are always older than live ones, so they are consumed first.
      resp_drop        = i_ImemRvalid & (drop_cnt != 2'd0);
      fill_hit         = i_ImemRvalid & (drop_cnt == 2'd0) & ent_vld[fill_ptr] & ~ent_fill[fill_ptr];
      head_rdy         = ent_vld[pop_ptr] & (ent_fill[pop_ptr] | (fill_hit & (fill_ptr == pop_ptr)));
      pop              = head_rdy & ~i_Stall & ~i_Redirect;
      head_dat         = ent_fill[pop_ptr] ? ent_dat[pop_ptr] : i_ImemRdata;
      redirect_aligned = i_RedirectPc & ~32'd3;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc   <= RESET_PC;
         ent_pc[0]  <= '0;
         ent_pc[1]  <= '0;
         ent_dat[0] <= '0;
         ent_dat[1] <= '0;
         ent_vld    <= '0;
         ent_fill   <= '0;
         alloc_ptr  <= 1'b0;
         fill_ptr   <= 1'b0;
         pop_ptr    <= 1'b0;
         drop_cnt   <= '0;
         o_Instr    <= NOP_INSTR;
         o_Pc       <= '0;
         o_Valid    <= 1'b0;
      end else if (i_Redirect) begin
         fetch_pc  <= redirect_aligned;
         ent_vld   <= '0;
         ent_fill  <= '0;
         alloc_ptr <= 1'b0;
         fill_ptr  <= 1'b0;
         pop_ptr   <= 1'b0;
         // Every outstanding unfilled request still owes a response that must be discarded.
         drop_cnt  <= drop_cnt - {1'b0, resp_drop} + unfilled - {1'b0, fill_hit};
         o_Valid   <= 1'b0;
         o_Instr   <= NOP_INSTR;
      end else begin
         if (accept) begin
            fetch_pc            <= fetch_pc + 32'd4;
            ent_vld[alloc_ptr]  <= 1'b1;
            ent_fill[alloc_ptr] <= 1'b0;
            ent_pc[alloc_ptr]   <= fetch_pc;
            alloc_ptr           <= ~alloc_ptr;
         end
         if (resp_drop) begin
            drop_cnt <= drop_cnt - 2'd1;
         end
         if (fill_hit) begin
            ent_fill[fill_ptr] <= 1'b1;
            ent_dat[fill_ptr]  <= i_ImemRdata;
            fill_ptr           <= ~fill_ptr;
         end
         if (pop) begin
            ent_vld[pop_ptr]  <= 1'b0;
            ent_fill[pop_ptr] <= 1'b0;
            pop_ptr           <= ~pop_ptr;
            o_Valid           <= 1'b1;
            o_Instr           <= head_dat;
            o_Pc              <= ent_pc[pop_ptr];
         end else if (!i_Stall) begin
            o_Valid <= 1'b0;
            o_Instr <= NOP_INSTR;
         end
      end
   end

endmodule
